// File: rtl/pipe_pattern_engine.sv
// BTPipeIn sequence checker and BTPipeOut sequence source sharing one
// pattern definition, with block-granular credit flags and first-error capture.
module pipe_pattern_engine #(
  parameter int WIDTH       = 16,
  parameter int ERR_W       = 16,
  parameter int BLOCK_WORDS = 256,
  parameter int THROTTLE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [31:0]      seed,
  input  logic             seed_load,
  input  logic             pipe_in_write,
  input  logic [WIDTH-1:0] pipe_in_data,
  output logic             pipe_in_ready,
  input  logic             pipe_out_read,
  output logic [WIDTH-1:0] pipe_out_data,
  output logic             pipe_out_valid,
  output logic [ERR_W-1:0] error_count,
  output logic [31:0]      word_count_in,
  output logic             overrun,
  output logic             first_err_valid,
  output logic [31:0]      first_err_index,
  output logic [WIDTH-1:0] first_err_expected,
  output logic [WIDTH-1:0] first_err_actual
);

  localparam int SW   = (WIDTH > 32) ? WIDTH : 32;
  localparam int CMAX = 2 * BLOCK_WORDS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = (THROTTLE > 1) ? $clog2(THROTTLE) : 1;

  typedef logic [SW-1:0]    st_t;
  typedef logic [WIDTH-1:0] w_t;
  typedef logic [CW-1:0]    cr_t;
  typedef logic [ERR_W-1:0] er_t;
  typedef logic [TW-1:0]    th_t;

  localparam cr_t CR_MAX = cr_t'(CMAX);
  localparam cr_t CR_BLK = cr_t'(BLOCK_WORDS);

  // Generator state is at least 32 bits so the LFSR fits at WIDTH=16.
  function automatic st_t gen_init(input logic [1:0] m,
                                   input logic [31:0] s);
    st_t r;
    r = '0;
    unique case (m)
      2'd0:    r[WIDTH-1:0] = w_t'(s);
      2'd1:    r[31:0] = (s == 32'h0) ? 32'h1 : s;
      2'd2:    r[0] = 1'b1;
      default: r[WIDTH-1:0] = {(WIDTH/2){2'b10}};
    endcase
    return r;
  endfunction

  function automatic st_t gen_step(input logic [1:0] m,
                                   input st_t st);
    st_t r;
    r = '0;
    unique case (m)
      2'd0: r[WIDTH-1:0] = st[WIDTH-1:0] + w_t'(1);
      2'd1: r[31:0] = {1'b0, st[31:1]}
                    ^ (st[0] ? 32'h8020_0003 : 32'h0);
      2'd2: r[WIDTH-1:0] = {st[WIDTH-2:0], st[WIDTH-1]};
      default: r[WIDTH-1:0] = ~st[WIDTH-1:0];
    endcase
    return r;
  endfunction

  function automatic w_t gen_word(input logic [1:0] m,
                                  input st_t st);
    w_t r;
    if (m == 2'd1) begin
      if (WIDTH == 64) r = w_t'({~st[31:0], st[31:0]});
      else             r = w_t'(st[31:0]);
    end else begin
      r = st[WIDTH-1:0];
    end
    return r;
  endfunction

  function automatic cr_t cred_next(input cr_t c,
                                    input logic stb,
                                    input logic tk);
    cr_t r;
    r = c;
    if (THROTTLE == 0)    r = CR_MAX;
    else if (stb && !tk)  r = (c == '0) ? c : c - cr_t'(1);
    else if (tk && !stb)  r = (c == CR_MAX) ? c : c + cr_t'(1);
    return r;
  endfunction

  logic [1:0] mode_q, mode_d;
  st_t        exp_q, exp_d;
  st_t        gen_q, gen_d;
  er_t        err_q, err_d;
  logic [31:0] wc_q, wc_d;
  logic       ovr_q, ovr_d;
  logic       fev_q, fev_d;
  logic [31:0] fei_q, fei_d;
  w_t         fee_q, fee_d;
  w_t         fea_q, fea_d;
  cr_t        icred_q, icred_d;
  cr_t        ocred_q, ocred_d;
  logic       irdy_q, irdy_d;
  logic       ovld_q, ovld_d;
  th_t        thr_q, thr_d;
  logic       tick;
  w_t         exp_w;

  assign exp_w = gen_word(mode_q, exp_q);

  always_comb begin
    mode_d  = mode_q;
    exp_d   = exp_q;
    gen_d   = gen_q;
    err_d   = err_q;
    wc_d    = wc_q;
    ovr_d   = ovr_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    fee_d   = fee_q;
    fea_d   = fea_q;
    tick    = (THROTTLE > 0) && (thr_q == th_t'(THROTTLE - 1));
    thr_d   = tick ? '0 : thr_q + th_t'(1);
    icred_d = cred_next(icred_q, pipe_in_write, tick);
    ocred_d = cred_next(ocred_q, pipe_out_read, tick);
    irdy_d  = (icred_q >= CR_BLK);
    ovld_d  = (ocred_q >= CR_BLK);
    if (seed_load) begin
      mode_d = mode;
      exp_d  = gen_init(mode, seed);
      gen_d  = gen_init(mode, seed);
      err_d  = '0;
      wc_d   = '0;
      ovr_d  = 1'b0;
      fev_d  = 1'b0;
      fei_d  = '0;
      fee_d  = '0;
      fea_d  = '0;
    end else begin
      if (pipe_in_write) begin
        exp_d = gen_step(mode_q, exp_q);
        wc_d  = wc_q + 32'd1;
        if (icred_q == '0) ovr_d = 1'b1;
        if (pipe_in_data != exp_w) begin
          if (err_q != '1) err_d = err_q + er_t'(1);
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = wc_q;
            fee_d = exp_w;
            fea_d = pipe_in_data;
          end
        end
      end
      if (pipe_out_read) gen_d = gen_step(mode_q, gen_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= mode;
      exp_q   <= gen_init(mode, seed);
      gen_q   <= gen_init(mode, seed);
      err_q   <= '0;
      wc_q    <= '0;
      ovr_q   <= 1'b0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      fee_q   <= '0;
      fea_q   <= '0;
      icred_q <= CR_MAX;
      ocred_q <= CR_MAX;
      irdy_q  <= 1'b0;
      ovld_q  <= 1'b0;
      thr_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      exp_q   <= exp_d;
      gen_q   <= gen_d;
      err_q   <= err_d;
      wc_q    <= wc_d;
      ovr_q   <= ovr_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      fee_q   <= fee_d;
      fea_q   <= fea_d;
      icred_q <= icred_d;
      ocred_q <= ocred_d;
      irdy_q  <= irdy_d;
      ovld_q  <= ovld_d;
      thr_q   <= thr_d;
    end
  end

  assign pipe_in_ready      = irdy_q;
  assign pipe_out_valid     = ovld_q;
  assign pipe_out_data      = gen_word(mode_q, gen_q);
  assign error_count        = err_q;
  assign word_count_in      = wc_q;
  assign overrun            = ovr_q;
  assign first_err_valid    = fev_q;
  assign first_err_index    = fei_q;
  assign first_err_expected = fee_q;
  assign first_err_actual   = fea_q;

endmodule

// File: tb/tb_pipe_pattern_engine.sv
// Bench for pipe_pattern_engine: three instances (16/32/64-bit) driven
// from a vector table plus hand sequences for credits and seed_load.
module tb_pipe_pattern_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, seed_load, wr, rd;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [63:0] wd;
  int          sel;

  logic        wr16, rd16, rdy16, val16, ovr16, fev16;
  logic [15:0] q16, fee16, fea16;
  logic [3:0]  err16;
  logic [31:0] wc16, fei16;

  logic        wr32, rd32, rdy32, val32, ovr32, fev32;
  logic [31:0] q32, fee32, fea32;
  logic [15:0] err32;
  logic [31:0] wc32, fei32;

  logic        wr64, rd64, rdy64, val64, ovr64, fev64;
  logic [63:0] q64, fee64, fea64;
  logic [15:0] err64;
  logic [31:0] wc64, fei64;

  assign wr16 = wr && (sel == 0);
  assign rd16 = rd && (sel == 0);
  assign wr32 = wr && (sel == 1);
  assign rd32 = rd && (sel == 1);
  assign wr64 = wr && (sel == 2);
  assign rd64 = rd && (sel == 2);

  pipe_pattern_engine #(.WIDTH(16), .ERR_W(4),
    .BLOCK_WORDS(16), .THROTTLE(4)) u16 (
    .clk(clk), .reset(reset), .mode(mode), .seed(seed),
    .seed_load(seed_load), .pipe_in_write(wr16),
    .pipe_in_data(wd[15:0]), .pipe_in_ready(rdy16),
    .pipe_out_read(rd16), .pipe_out_data(q16),
    .pipe_out_valid(val16), .error_count(err16),
    .word_count_in(wc16), .overrun(ovr16),
    .first_err_valid(fev16), .first_err_index(fei16),
    .first_err_expected(fee16), .first_err_actual(fea16));

  pipe_pattern_engine #(.WIDTH(32), .ERR_W(16),
    .BLOCK_WORDS(256), .THROTTLE(0)) u32 (
    .clk(clk), .reset(reset), .mode(mode), .seed(seed),
    .seed_load(seed_load), .pipe_in_write(wr32),
    .pipe_in_data(wd[31:0]), .pipe_in_ready(rdy32),
    .pipe_out_read(rd32), .pipe_out_data(q32),
    .pipe_out_valid(val32), .error_count(err32),
    .word_count_in(wc32), .overrun(ovr32),
    .first_err_valid(fev32), .first_err_index(fei32),
    .first_err_expected(fee32), .first_err_actual(fea32));

  pipe_pattern_engine #(.WIDTH(64), .ERR_W(16),
    .BLOCK_WORDS(8), .THROTTLE(0)) u64 (
    .clk(clk), .reset(reset), .mode(mode), .seed(seed),
    .seed_load(seed_load), .pipe_in_write(wr64),
    .pipe_in_data(wd), .pipe_in_ready(rdy64),
    .pipe_out_read(rd64), .pipe_out_data(q64),
    .pipe_out_valid(val64), .error_count(err64),
    .word_count_in(wc64), .overrun(ovr64),
    .first_err_valid(fev64), .first_err_index(fei64),
    .first_err_expected(fee64), .first_err_actual(fea64));

  logic [63:0] o_q, o_rdy, o_val, o_err, o_wc, o_ovr;
  logic [63:0] o_fev, o_fei, o_fee, o_fea;

  always_comb begin
    o_q = '0; o_rdy = '0; o_val = '0; o_err = '0; o_wc = '0;
    o_ovr = '0; o_fev = '0; o_fei = '0; o_fee = '0; o_fea = '0;
    case (sel)
      0: begin
        o_q = 64'(q16); o_rdy = 64'(rdy16); o_val = 64'(val16);
        o_err = 64'(err16); o_wc = 64'(wc16); o_ovr = 64'(ovr16);
        o_fev = 64'(fev16); o_fei = 64'(fei16);
        o_fee = 64'(fee16); o_fea = 64'(fea16);
      end
      1: begin
        o_q = 64'(q32); o_rdy = 64'(rdy32); o_val = 64'(val32);
        o_err = 64'(err32); o_wc = 64'(wc32); o_ovr = 64'(ovr32);
        o_fev = 64'(fev32); o_fei = 64'(fei32);
        o_fee = 64'(fee32); o_fea = 64'(fea32);
      end
      default: begin
        o_q = q64; o_rdy = 64'(rdy64); o_val = 64'(val64);
        o_err = 64'(err64); o_wc = 64'(wc64); o_ovr = 64'(ovr64);
        o_fev = 64'(fev64); o_fei = 64'(fei64);
        o_fee = fee64; o_fea = fea64;
      end
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << w) - 64'h1);
  endfunction

  function automatic int wsel(input int s);
    return (s == 0) ? 16 : ((s == 1) ? 32 : 64);
  endfunction

  // k-th word of the reference sequence
  function automatic logic [63:0] mdl(input int w, input logic [1:0] m,
                                      input logic [31:0] s, input int k);
    logic [63:0] r;
    logic [31:0] l;
    case (m)
      2'd0: r = {32'h0, s} + 64'(k);
      2'd1: begin
        l = (s == 32'h0) ? 32'h1 : s;
        for (int i = 0; i < k; i++)
          l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        r = (w == 64) ? {~l, l} : {32'h0, l};
      end
      2'd2: r = 64'h1 << (k % w);
      default: r = (k % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA
                                : 64'h5555_5555_5555_5555;
    endcase
    return r & wmask(w);
  endfunction

  typedef struct {
    int          inst;
    logic [1:0]  m;
    logic [31:0] s;
    int          n;
    int          bf;
    int          bt;
    int          e_err;
  } vec_t;

  vec_t        vt[9];
  logic [63:0] sb[$];
  int          cm, tc;
  logic        rm, om;

  task automatic do_reset(input logic [1:0] m, input logic [31:0] s);
    reset = 1'b1; mode = m; seed = s;
    wr = 1'b0; rd = 1'b0; seed_load = 1'b0; wd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // credit and overrun reference for u16 (BLOCK_WORDS=16, THROTTLE=4)
  task automatic mstep(input logic w, input logic sl);
    logic tk;
    tk = (tc == 3);
    tc = tk ? 0 : tc + 1;
    rm = (cm >= 16);
    if (sl) om = 1'b0;
    else if (w && cm == 0) om = 1'b1;
    if (w && !tk) cm = (cm == 0) ? 0 : cm - 1;
    else if (tk && !w) cm = (cm == 32) ? 32 : cm + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] e, got, fe;
    int w, dut_low;
    vt[0] = '{0, 2'd0, 32'h0000_0005, 256, -1, -1, 0};
    vt[1] = '{1, 2'd1, 32'h0000_0000, 1000, -1, -1, 0};
    vt[2] = '{0, 2'd2, 32'h0000_0000, 20, 5, 5, 1};
    vt[3] = '{0, 2'd0, 32'h0000_1234, 20, 0, 19, 15};
    vt[4] = '{2, 2'd0, 32'hFFFF_FFFE, 10, -1, -1, 0};
    vt[5] = '{2, 2'd1, 32'h1234_5678, 40, 3, 4, 2};
    vt[6] = '{1, 2'd3, 32'h0000_0000, 9, 8, 8, 1};
    vt[7] = '{0, 2'd1, 32'h0000_ACE1, 30, -1, -1, 0};
    vt[8] = '{2, 2'd2, 32'h0000_0000, 70, 65, 65, 1};

    // reset state
    sel = 0; reset = 1'b1; mode = 2'd0; seed = '0;
    wr = 1'b0; rd = 1'b0; seed_load = 1'b0; wd = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", o_rdy, 64'd0);
    chk("rst_valid", o_val, 64'd0);
    chk("rst_err", o_err, 64'd0);
    chk("rst_wc", o_wc, 64'd0);
    chk("rst_ovr", o_ovr, 64'd0);
    chk("rst_fev", o_fev, 64'd0);
    chk("rst_fei", o_fei, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", o_rdy, 64'd1);
    chk("post_rst_valid", o_val, 64'd1);

    // table vectors
    foreach (vt[i]) begin
      sel = vt[i].inst;
      w   = wsel(sel);
      do_reset(vt[i].m, vt[i].s);
      for (int k = 0; k < vt[i].n; k++) begin
        wd = mdl(w, vt[i].m, vt[i].s, k);
        if (k >= vt[i].bf && k <= vt[i].bt) wd = ~wd & wmask(w);
        wr = 1'b1;
        @(negedge clk);
      end
      wr = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_err", i), o_err, 64'(vt[i].e_err));
      chk($sformatf("v%0d_wc", i), o_wc, 64'(vt[i].n));
      if (vt[i].bf >= 0) begin
        fe = mdl(w, vt[i].m, vt[i].s, vt[i].bf);
        chk($sformatf("v%0d_fev", i), o_fev, 64'd1);
        chk($sformatf("v%0d_fei", i), o_fei, 64'(vt[i].bf));
        chk($sformatf("v%0d_fee", i), o_fee, fe);
        chk($sformatf("v%0d_fea", i), o_fea, ~fe & wmask(w));
      end else begin
        chk($sformatf("v%0d_fev", i), o_fev, 64'd0);
      end
      for (int k = 0; k < 4; k++) begin
        sb.push_back(mdl(w, vt[i].m, vt[i].s, k));
        rd  = 1'b1;
        got = o_q;
        e   = sb.pop_front();
        chk($sformatf("v%0d_rd%0d", i, k), got, e);
        @(negedge clk);
      end
      rd = 1'b0;
    end

    // walking-one with a zero word at index 5
    sel = 0;
    do_reset(2'd2, 32'h0);
    for (int k = 0; k < 20; k++) begin
      wd = (k == 5) ? 64'h0 : (64'h1 << (k % 16));
      wr = 1'b1;
      @(negedge clk);
    end
    wr = 1'b0;
    @(negedge clk);
    chk("walk_err", o_err, 64'd1);
    chk("walk_fei", o_fei, 64'd5);
    chk("walk_fee", o_fee, 64'h0020);
    chk("walk_fea", o_fea, 64'h0000);

    // credit drain, overrun, seed_load and replenish on u16
    sel = 0;
    do_reset(2'd0, 32'h0);
    cm = 32; tc = 1; rm = 1'b1; om = 1'b0; dut_low = 0;
    for (int i = 0; i < 200 && cm > 0; i++) begin
      wd = '0; wr = 1'b1;
      mstep(1'b1, 1'b0);
      @(negedge clk);
      chk("cr_ready", o_rdy, 64'(rm));
      chk("cr_ovr", o_ovr, 64'(om));
      if (o_rdy == 64'd0) dut_low = 1;
    end
    chk("cr_went_low", 64'(dut_low), 64'd1);
    mstep(1'b1, 1'b0);
    @(negedge clk);
    chk("cr_ovr_set", o_ovr, 64'(om));
    chk("cr_ovr_one", o_ovr, 64'd1);
    wr = 1'b0; seed_load = 1'b1;
    mstep(1'b0, 1'b1);
    @(negedge clk);
    seed_load = 1'b0;
    chk("sl_ovr", o_ovr, 64'd0);
    chk("sl_wc", o_wc, 64'd0);
    chk("sl_ready", o_rdy, 64'(rm));
    for (int i = 0; i < 200 && o_rdy != 64'd1; i++) begin
      mstep(1'b0, 1'b0);
      @(negedge clk);
      chk("rep_ready", o_rdy, 64'(rm));
    end
    chk("rep_ready_high", o_rdy, 64'd1);

    // reset mid-transfer
    wr = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_ready_low", o_rdy, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", o_rdy, 64'd0);
    chk("mid_rst_wc", o_wc, 64'd0);
    reset = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("mid_ready_back", o_rdy, 64'd1);
    chk("mid_valid_back", o_val, 64'd1);

    // alternating 64-bit, mode change ignored, seed_load mid-block
    sel = 2;
    do_reset(2'd3, 32'h0);
    mode = 2'd0;
    for (int k = 0; k < 7; k++) begin
      wd = (k % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA
                        : 64'h5555_5555_5555_5555;
      wr = 1'b1;
      @(negedge clk);
    end
    wr = 1'b0;
    @(negedge clk);
    chk("alt_err", o_err, 64'd0);
    chk("alt_wc", o_wc, 64'd7);
    mode = 2'd3;
    seed_load = 1'b1; wr = 1'b1; wd = 64'h0;
    @(negedge clk);
    seed_load = 1'b0; wr = 1'b0;
    chk("alt_sl_wc", o_wc, 64'd0);
    chk("alt_sl_err", o_err, 64'd0);
    chk("alt_sl_ready", o_rdy, 64'd1);
    wd = 64'hAAAA_AAAA_AAAA_AAAA; wr = 1'b1;
    @(negedge clk);
    wd = 64'h5555_5555_5555_5555;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    chk("alt_post_err", o_err, 64'd0);
    chk("alt_post_wc", o_wc, 64'd2);
    chk("alt_post_fev", o_fev, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
